// File: rtl/alu_muldiv.sv
// alu_muldiv: EX-stage ALU with single-cycle logic/arith ops plus an iterative
// radix-2 multiply/divide unit that writes HI/LO.
// Optional feature macro: ALU_OVF_EN (registered signed ADD/SUB overflow on ovf).
// Handshake: start is sampled only in IDLE (ignored otherwise, never queued);
// done is a one-cycle pulse meaning result/zero/HI/LO were updated at the
// preceding edge; busy is high while a mul/div iterates, and the controller
// stalls on it.
module alu_muldiv #(
  parameter int WIDTH = 32,
  parameter int OPW   = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [OPW-1:0]   aluop,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             busy,
  output logic             done,
  output logic             dz,
  output logic             ovf,
  output logic [1:0]       dbg_state
);

  localparam int CW = $clog2(WIDTH) + 1;

  localparam logic [OPW-1:0] OP_AND   = OPW'(0);
  localparam logic [OPW-1:0] OP_OR    = OPW'(1);
  localparam logic [OPW-1:0] OP_ADD   = OPW'(2);
  localparam logic [OPW-1:0] OP_XOR   = OPW'(3);
  localparam logic [OPW-1:0] OP_NOR   = OPW'(4);
  localparam logic [OPW-1:0] OP_SLTU  = OPW'(5);
  localparam logic [OPW-1:0] OP_SUB   = OPW'(6);
  localparam logic [OPW-1:0] OP_SLT   = OPW'(7);
  localparam logic [OPW-1:0] OP_MULT  = OPW'(8);
  localparam logic [OPW-1:0] OP_MULTU = OPW'(9);
  localparam logic [OPW-1:0] OP_DIV   = OPW'(10);
  localparam logic [OPW-1:0] OP_DIVU  = OPW'(11);
  localparam logic [OPW-1:0] OP_MFHI  = OPW'(12);
  localparam logic [OPW-1:0] OP_MFLO  = OPW'(13);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_FIN  = 2'd2
  } state_t;

  state_t             state, state_nxt;
  logic [CW-1:0]      cnt;
  logic [WIDTH-1:0]   hi, lo;
  logic [WIDTH-1:0]   opd;       // multiplicand or divisor magnitude
  logic [WIDTH-1:0]   a_q;       // raw dividend, needed for the b==0 case
  logic [2*WIDTH-1:0] acc;       // {partial product, multiplier} or {remainder, quotient}
  logic               is_div_q, neg_q, neg_r, bz_q;

  logic               is_muldiv, is_signed, is_div, a_neg, b_neg;
  logic [WIDTH-1:0]   mag_a, mag_b, sum, diff, alu_y;
  logic [WIDTH:0]     mul_sum, div_rs, div_diff;
  logic [2*WIDTH-1:0] step_nxt, prod;
  logic [WIDTH-1:0]   quo, rem, fin_hi, fin_lo;

  // Decode the request and compute every single-cycle result.
  always_comb begin
    is_muldiv = (aluop == OP_MULT) || (aluop == OP_MULTU) ||
                (aluop == OP_DIV)  || (aluop == OP_DIVU);
    is_signed = (aluop == OP_MULT) || (aluop == OP_DIV);
    is_div    = (aluop == OP_DIV)  || (aluop == OP_DIVU);
    a_neg     = is_signed & a[WIDTH-1];
    b_neg     = is_signed & b[WIDTH-1];
    mag_a     = a_neg ? ('0 - a) : a;
    mag_b     = b_neg ? ('0 - b) : b;
    sum       = a + b;
    diff      = a - b;
    alu_y     = '0;
    case (aluop)
      OP_AND:  alu_y = a & b;
      OP_OR:   alu_y = a | b;
      OP_ADD:  alu_y = sum;
      OP_XOR:  alu_y = a ^ b;
      OP_NOR:  alu_y = ~(a | b);
      OP_SLTU: alu_y = WIDTH'(a < b);
      OP_SUB:  alu_y = diff;
      OP_SLT:  alu_y = WIDTH'($signed(a) < $signed(b));
      OP_MFHI: alu_y = hi;
      OP_MFLO: alu_y = lo;
      default: alu_y = '0;
    endcase
  end

  // One radix-2 iteration: shift-add for multiply, restoring shift-subtract for divide.
  always_comb begin
    mul_sum  = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, opd} : '0);
    div_rs   = acc[2*WIDTH-1:WIDTH-1];
    div_diff = div_rs - {1'b0, opd};
    if (is_div_q) begin
      if (div_diff[WIDTH])
        step_nxt = {div_rs[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};
      else
        step_nxt = {div_diff[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
    end else begin
      step_nxt = {mul_sum, acc[WIDTH-1:1]};
    end
  end

  // Sign fix-up of the unsigned iteration result and final HI/LO values.
  always_comb begin
    prod = neg_q ? ('0 - acc) : acc;
    quo  = neg_q ? ('0 - acc[WIDTH-1:0]) : acc[WIDTH-1:0];
    rem  = neg_r ? ('0 - acc[2*WIDTH-1:WIDTH]) : acc[2*WIDTH-1:WIDTH];
    if (is_div_q) begin
      if (bz_q) begin
        fin_hi = a_q;
        fin_lo = '1;
      end else begin
        fin_hi = rem;
        fin_lo = quo;
      end
    end else begin
      fin_hi = prod[2*WIDTH-1:WIDTH];
      fin_lo = prod[WIDTH-1:0];
    end
  end

  // FSM state register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nxt;
  end

  // FSM next-state and status outputs.
  always_comb begin
    state_nxt = state;
    busy      = 1'b0;
    case (state)
      S_IDLE: if (start && is_muldiv) state_nxt = S_RUN;
      S_RUN: begin
        busy = 1'b1;
        if (cnt == CW'(WIDTH - 1)) state_nxt = S_FIN;
      end
      S_FIN:   state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  assign dbg_state = state;

  // Datapath: operand capture, iteration, HI/LO write-back and result registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      result   <= '0;
      zero     <= 1'b1;
      done     <= 1'b0;
      dz       <= 1'b0;
      hi       <= '0;
      lo       <= '0;
      cnt      <= '0;
      acc      <= '0;
      opd      <= '0;
      a_q      <= '0;
      is_div_q <= 1'b0;
      neg_q    <= 1'b0;
      neg_r    <= 1'b0;
      bz_q     <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            dz <= 1'b0;
            if (is_muldiv) begin
              acc      <= {{WIDTH{1'b0}}, mag_a};
              opd      <= mag_b;
              a_q      <= a;
              is_div_q <= is_div;
              neg_q    <= a_neg ^ b_neg;
              neg_r    <= a_neg;
              bz_q     <= (b == '0);
              cnt      <= '0;
            end else begin
              result <= alu_y;
              zero   <= (alu_y == '0);
              done   <= 1'b1;
            end
          end
        end
        S_RUN: begin
          acc <= step_nxt;
          cnt <= cnt + CW'(1);
        end
        S_FIN: begin
          hi     <= fin_hi;
          lo     <= fin_lo;
          result <= fin_lo;
          zero   <= (fin_lo == '0);
          done   <= 1'b1;
          dz     <= is_div_q & bz_q;
        end
        default: ;
      endcase
    end
  end

`ifdef ALU_OVF_EN
  logic ovf_c;

  // Signed overflow of the single-cycle ADD/SUB; every other op reports 0.
  always_comb begin
    ovf_c = 1'b0;
    if (aluop == OP_ADD)
      ovf_c = (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
    else if (aluop == OP_SUB)
      ovf_c = (a[WIDTH-1] != b[WIDTH-1]) && (diff[WIDTH-1] != a[WIDTH-1]);
  end

  // ovf is written whenever result is written.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      ovf <= 1'b0;
    else if (state == S_IDLE && start && !is_muldiv)
      ovf <= ovf_c;
    else if (state == S_FIN)
      ovf <= 1'b0;
  end
`else
  assign ovf = 1'b0;
`endif

endmodule
